// File: rtl/mdu32.sv
// Iterative 32-bit multiply/divide unit for the MIPS EX stage.
// Shift-add multiply and restoring divide share one 64-bit accumulator; HI/LO change only on FIX exit or MT ops.
module mdu32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic [1:0]  state;
    logic [4:0]  count;
    logic        is_div;
    logic        neg_q;     // product or quotient sign
    logic        neg_r;     // remainder sign
    logic        div_zero;
    logic [31:0] opnd;      // multiplicand or divisor magnitude
    logic [31:0] a_save;
    logic [63:0] acc;

    logic        is_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] mul_sum;
    logic [32:0] div_diff;
    logic [63:0] acc_step;
    logic [63:0] product;
    logic [31:0] quot_fixed;
    logic [31:0] rem_fixed;

    assign busy      = (state != ST_IDLE);
    assign is_signed = op[0];
    assign abs_a     = (is_signed && a[31]) ? (32'd0 - a) : a;
    assign abs_b     = (is_signed && b[31]) ? (32'd0 - b) : b;

    // Multiply: acc = {partial, multiplier}, add on LSB then shift right.
    // Divide:   acc = {remainder, dividend/quotient}, trial-subtract on the shifted remainder.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        acc_step = acc;
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        div_diff = acc[63:31] - {1'b0, opnd};
        if (is_div) begin
            if (div_diff[32])
                acc_step = {acc[62:0], 1'b0};
            else
                acc_step = {div_diff[31:0], acc[30:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc[31:1]};
        end
    end

    always_comb begin
        product    = neg_q ? (64'd0 - acc) : acc;
        quot_fixed = neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
        rem_fixed  = neg_r ? (32'd0 - acc[63:32]) : acc[63:32];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            count    <= 5'd0;
            done     <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            opnd     <= 32'd0;
            a_save   <= 32'd0;
            acc      <= 64'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        case (op)
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            OP_MULTU, OP_MULT: begin
                                state  <= ST_CALC;
                                count  <= 5'd0;
                                is_div <= 1'b0;
                                neg_q  <= is_signed & (a[31] ^ b[31]);
                                neg_r  <= 1'b0;
                                opnd   <= abs_a;
                                acc    <= {32'd0, abs_b};
                            end
                            OP_DIVU, OP_DIV: begin
                                state    <= ST_CALC;
                                count    <= 5'd0;
                                is_div   <= 1'b1;
                                neg_q    <= is_signed & (a[31] ^ b[31]);
                                neg_r    <= is_signed & a[31];
                                div_zero <= (b == 32'd0);
                                a_save   <= a;
                                opnd     <= abs_b;
                                acc      <= {32'd0, abs_a};
                            end
                            default: ;
                        endcase
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        acc   <= acc_step;
                        count <= count + 5'd1;
                        if (count == 5'd31)
                            state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state <= ST_IDLE;
                    if (!flush) begin
                        done <= 1'b1;
                        if (!is_div) begin
                            hi <= product[63:32];
                            lo <= product[31:0];
                        end else if (div_zero) begin
                            hi <= a_save;
                            lo <= 32'hFFFF_FFFF;
                        end else begin
                            hi <= rem_fixed;
                            lo <= quot_fixed;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mdu32.md
# mdu32

Iterative 32-bit multiply/divide unit that sits in the EX stage of the pipelined MIPS core, beside the ALU, and takes the same ID/EX operands. It runs MULT/MULTU/DIV/DIVU over several cycles into the architectural HI/LO registers, and handles MTHI/MTLO. It drives `busy` so the hazard unit can stall the pipeline. MFHI/MFLO read the `hi`/`lo` outputs directly.

## Interface
- No parameters; the datapath is fixed at 32 bits.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue request; sampled only when `busy`=0.
- `op`  in  3  operation: 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x reserved (treated as no-op).
- `a`  in  32  rs operand (multiplicand / dividend / MT source).
- `b`  in  32  rt operand (multiplier / divisor).
- `flush`  in  1  abort the in-flight operation (branch/exception squash).
- `busy`  out  1  operation in progress; the hazard unit stalls MDU-dependent instructions.
- `done`  out  1  one-cycle pulse when HI/LO are updated by a mul/div.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, CALC, FIX. `busy` = (state != IDLE).
- IDLE with `start`=1:
  - MT ops: write `hi` (MTHI) or `lo` (MTLO) from `a` at that edge. State stays IDLE, no `done`.
  - Mul/div ops: latch the operation, then go to CALC with count=0.
- Operand preparation for signed ops: use |a| and |b| internally. Record the result signs:
  - product sign = a[31]^b[31];
  - quotient sign = a[31]^b[31];
  - remainder sign = a[31].
- CALC runs one iteration per cycle for count 0..31, then moves to FIX after the 32nd iteration.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring; 32-bit remainder plus quotient shift register.
- FIX applies sign correction (two's-complement negate where the recorded sign is 1) and writes the results:
  - multiply: hi=product[63:32], lo=product[31:0];
  - divide: lo=quotient, hi=remainder.
  - Then returns to IDLE with `done`=1 for one cycle.
- Divide by zero (b=0, DIV or DIVU): lo=0xFFFFFFFF, hi=a. No exception; normal latency.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
- `start` while `busy`=1 is ignored; the op is not queued. The hazard unit keeps the instruction stalled.
- `flush`=1 while busy: return to IDLE at the next edge, hi/lo unchanged, no `done`.
- `flush` and `start` together in IDLE: `flush` wins and the op is not accepted.
- Reserved `op` with `start`: no state change.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, count=0. Reset mid-operation discards the operation immediately.
- Mul/div latency, with start accepted at edge E0:
  - `busy` goes high after E0;
  - iterations run at E1..E32;
  - FIX completes at E33: `hi`/`lo` update, `busy` falls, and `done` is high for the cycle after E33.
  - Total: 33 busy cycles; results visible 33 cycles after acceptance.
- Back-to-back issue: a new `start` is accepted in the cycle where `done`=1, since `busy`=0.
- MTHI/MTLO latency: value visible on `hi`/`lo` the cycle after E0.
- `hi`/`lo` are stable at all times except the FIX-exit edge and MT edges. Intermediate CALC values never reach the outputs.
- Operands `a`/`b`/`op` need only be valid in the accepting cycle; they are registered at E0.

## Test plan
- Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, `done` single pulse, `busy` high exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3) b=0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; then DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=0x00000064 b=0 -> lo=0xFFFFFFFF, hi=0x00000064. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 on consecutive cycles -> hi/lo show the values one cycle after each, `busy` stays 0. A MTHI issued while busy leaves hi unchanged.
- MULTU issued, `flush` at E10 -> `busy` falls next cycle, no `done`, hi/lo keep their prior values. Repeat with rst_n low at E20 -> hi=lo=0 asynchronously.
- Back-to-back: DIVU 100/7 issued in the `done` cycle of a prior MULTU 6*7 -> first result hi=0, lo=42; second result lo=14, hi=2, 33 cycles later.
